// File: rtl/regfile_sequencer.sv
// Command sequencer that turns single register-file operations into cycle-accurate
// register-file control. Define REGSEQ_SWAP_EN to build in the three-cycle SWAP command.
module regfile_sequencer #(
    parameter logic [2:0] FS_DEC   = 3'b000,
    parameter logic [2:0] FS_INC   = 3'b001,
    parameter logic [2:0] FS_LOAD  = 3'b010,
    parameter logic [2:0] FS_CLEAR = 3'b011
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [2:0]  CmdOp,
    input  logic [1:0]  CmdDst,
    input  logic [1:0]  CmdSrc,
    input  logic [15:0] CmdData,
    input  logic [15:0] RfOutA,
    output logic [15:0] RfI,
    output logic [2:0]  RfOutASel,
    output logic [2:0]  RfOutBSel,
    output logic [2:0]  RfFunSel,
    output logic [3:0]  RfRegSel,
    output logic [3:0]  RfScrSel,
    output logic        Done,
    output logic        Err
);

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_CLR  = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam logic [2:0] OP_DEC  = 3'b100;
    localparam logic [2:0] OP_MOV  = 3'b101;
    localparam logic [2:0] OP_SWAP = 3'b110;

`ifdef REGSEQ_SWAP_EN
    typedef enum logic [1:0] {IDLE, EXEC, SWAP2, SWAP3} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC} state_t;
`endif

    typedef enum logic [1:0] {ISEL_ZERO, ISEL_DATA, ISEL_OUTA} isel_t;

    typedef struct packed {
        logic [3:0] regsel;
        logic [3:0] scrsel;
        logic [2:0] funsel;
        logic [2:0] outasel;
        isel_t      isel;
        logic       done;
        logic       err;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{regsel: 4'b1111, scrsel: 4'b1111, funsel: 3'b000,
                                    outasel: 3'b000, isel: ISEL_ZERO, done: 1'b0, err: 1'b0};

    state_t      state, nstate;
    logic [2:0]  op_p0, nop;
    logic [1:0]  dst_p0, ndst;
    logic [1:0]  src_p0, nsrc;
    logic [15:0] data_p0, ndata;
    ctrl_t       ctrl_p0, nctrl;

    // Active-low one-hot enable; index 0 (R1/S1) maps to bit 3.
    function automatic logic [3:0] en_mask(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

    function automatic ctrl_t decode(input state_t s, input logic [2:0] op,
                                     input logic [1:0] dst, input logic [1:0] src);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            EXEC: begin
                c.done = 1'b1;
                case (op)
                    OP_NOP: ;
                    OP_LDI: begin
                        c.regsel = en_mask(dst);
                        c.funsel = FS_LOAD;
                        c.isel   = ISEL_DATA;
                    end
                    OP_CLR: begin
                        c.regsel = en_mask(dst);
                        c.funsel = FS_CLEAR;
                    end
                    OP_INC: begin
                        c.regsel = en_mask(dst);
                        c.funsel = FS_INC;
                    end
                    OP_DEC: begin
                        c.regsel = en_mask(dst);
                        c.funsel = FS_DEC;
                    end
                    OP_MOV: begin
                        c.outasel = {1'b0, src};
                        c.isel    = ISEL_OUTA;
                        c.regsel  = en_mask(dst);
                        c.funsel  = FS_LOAD;
                    end
`ifdef REGSEQ_SWAP_EN
                    OP_SWAP: begin
                        // First leg parks R[dst] in S1; completion is signalled in SWAP3.
                        c.outasel = {1'b0, dst};
                        c.isel    = ISEL_OUTA;
                        c.scrsel  = 4'b0111;
                        c.funsel  = FS_LOAD;
                        c.done    = 1'b0;
                    end
`endif
                    default: c.err = 1'b1;
                endcase
            end
`ifdef REGSEQ_SWAP_EN
            SWAP2: begin
                c.outasel = {1'b0, src};
                c.isel    = ISEL_OUTA;
                c.regsel  = en_mask(dst);
                c.funsel  = FS_LOAD;
            end
            SWAP3: begin
                c.outasel = 3'b100;
                c.isel    = ISEL_OUTA;
                c.regsel  = en_mask(src);
                c.funsel  = FS_LOAD;
                c.done    = 1'b1;
            end
`endif
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        nstate = state;
        nop    = op_p0;
        ndst   = dst_p0;
        nsrc   = src_p0;
        ndata  = data_p0;
        case (state)
            IDLE: begin
                if (CmdValid) begin
                    nop    = CmdOp;
                    ndst   = CmdDst;
                    nsrc   = CmdSrc;
                    ndata  = CmdData;
                    nstate = EXEC;
                end
            end
            EXEC: begin
`ifdef REGSEQ_SWAP_EN
                nstate = (op_p0 == OP_SWAP) ? SWAP2 : IDLE;
`else
                nstate = IDLE;
`endif
            end
`ifdef REGSEQ_SWAP_EN
            SWAP2: nstate = SWAP3;
            SWAP3: nstate = IDLE;
`endif
            default: nstate = IDLE;
        endcase
        nctrl = decode(nstate, nop, ndst, nsrc);
    end

    // Controls are registered against the state they belong to, so Cmd* never reaches Rf* directly.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            op_p0   <= '0;
            dst_p0  <= '0;
            src_p0  <= '0;
            data_p0 <= '0;
            ctrl_p0 <= CTRL_IDLE;
        end else begin
            state   <= nstate;
            op_p0   <= nop;
            dst_p0  <= ndst;
            src_p0  <= nsrc;
            data_p0 <= ndata;
            ctrl_p0 <= nctrl;
        end
    end

    // RfOutA is the register file's answer to our own registered OutASel.
    always_comb begin
        case (ctrl_p0.isel)
            ISEL_DATA: RfI = data_p0;
            ISEL_OUTA: RfI = RfOutA;
            default:   RfI = 16'h0000;
        endcase
    end

    assign CmdReady  = (state == IDLE);
    assign RfOutASel = ctrl_p0.outasel;
    assign RfOutBSel = 3'b000;
    assign RfFunSel  = ctrl_p0.funsel;
    assign RfRegSel  = ctrl_p0.regsel;
    assign RfScrSel  = ctrl_p0.scrsel;
    assign Done      = ctrl_p0.done;
    assign Err       = ctrl_p0.err;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized bench for regfile_sequencer with a behavioural register file and a
// command-level reference model; honours REGSEQ_SWAP_EN like the design.
module tb_regfile_sequencer;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LDI  = 3'd1;
    localparam logic [2:0] OP_CLR  = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_MOV  = 3'd5;
    localparam logic [2:0] OP_SWAP = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;
`ifdef REGSEQ_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic        CmdValid, CmdReady;
    logic [2:0]  CmdOp;
    logic [1:0]  CmdDst, CmdSrc;
    logic [15:0] CmdData, RfOutA, RfI;
    logic [2:0]  RfOutASel, RfOutBSel, RfFunSel;
    logic [3:0]  RfRegSel, RfScrSel;
    logic        Done, Err;

    regfile_sequencer dut (
        .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
        .CmdOp(CmdOp), .CmdDst(CmdDst), .CmdSrc(CmdSrc), .CmdData(CmdData),
        .RfOutA(RfOutA), .RfI(RfI), .RfOutASel(RfOutASel), .RfOutBSel(RfOutBSel),
        .RfFunSel(RfFunSel), .RfRegSel(RfRegSel), .RfScrSel(RfScrSel),
        .Done(Done), .Err(Err)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Behavioural register file the sequencer drives.
    logic [15:0] rf_r [4];
    logic [15:0] rf_s [4];
    assign RfOutA = RfOutASel[2] ? rf_s[RfOutASel[1:0]] : rf_r[RfOutASel[1:0]];

    function automatic logic [15:0] rf_apply(input logic [15:0] v);
        case (RfFunSel)
            3'b000:  return v - 16'd1;
            3'b001:  return v + 16'd1;
            3'b010:  return RfI;
            3'b011:  return 16'h0000;
            default: return v;
        endcase
    endfunction

    always @(posedge Clock) begin
        for (int k = 0; k < 4; k++) begin
            if (!RfRegSel[3-k]) rf_r[k] <= rf_apply(rf_r[k]);
            if (!RfScrSel[3-k]) rf_s[k] <= rf_apply(rf_s[k]);
        end
    end

    int viol = 0;
    always @(negedge Clock) begin
        int z;
        z = 0;
        for (int k = 0; k < 4; k++) z += int'(!RfRegSel[k]) + int'(!RfScrSel[k]);
        if (z > 1 || (CmdReady && z != 0)) viol++;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Command-level reference: register contents after each completed command.
    logic [15:0] ref_r [4];

    task automatic ref_apply(input logic [2:0] op, input logic [1:0] dst,
                             input logic [1:0] src, input logic [15:0] data);
        logic [15:0] t;
        case (op)
            OP_LDI: ref_r[dst] = data;
            OP_CLR: ref_r[dst] = 16'h0000;
            OP_INC: ref_r[dst] = ref_r[dst] + 16'd1;
            OP_DEC: ref_r[dst] = ref_r[dst] - 16'd1;
            OP_MOV: ref_r[dst] = ref_r[src];
            OP_SWAP: if (SWAP_EN) begin
                t = ref_r[dst];
                ref_r[dst] = ref_r[src];
                ref_r[src] = t;
            end
            default: ;
        endcase
    endtask

    logic [3:0]  sn_regsel [1:3];
    logic [3:0]  sn_scrsel [1:3];
    logic [2:0]  sn_fun    [1:3];
    logic [2:0]  sn_outa   [1:3];
    logic [15:0] sn_rfi    [1:3];
    logic        sn_done   [1:3];
    logic        sn_ready  [1:3];
    logic        sn_idle_ready, sn_idle_done, sn_idle_err;

    // Issues one command from IDLE and follows it to completion; called #1 after a rising edge.
    task automatic run_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                           input logic [15:0] data, input string tag);
        int budget, lat, exp_lat;
        bit got;
        logic err_seen, exp_err;
        budget = 0;
        while (!CmdReady && budget < 10) begin
            @(posedge Clock); #1;
            budget++;
        end
        CmdValid = 1'b1; CmdOp = op; CmdDst = dst; CmdSrc = src; CmdData = data;
        @(posedge Clock); #1;
        CmdValid = 1'b0;
        CmdOp = 3'($urandom); CmdDst = 2'($urandom); CmdSrc = 2'($urandom); CmdData = 16'($urandom);
        lat = -1; err_seen = 1'b0; got = 1'b0;
        for (int i = 1; i <= 6 && !got; i++) begin
            if (i <= 3) begin
                sn_regsel[i] = RfRegSel; sn_scrsel[i] = RfScrSel; sn_fun[i] = RfFunSel;
                sn_outa[i] = RfOutASel; sn_rfi[i] = RfI; sn_done[i] = Done; sn_ready[i] = CmdReady;
            end
            if (Done) begin
                lat = i; err_seen = Err; got = 1'b1;
            end else begin
                @(posedge Clock); #1;
            end
        end
        @(posedge Clock); #1;
        sn_idle_ready = CmdReady; sn_idle_done = Done; sn_idle_err = Err;
        ref_apply(op, dst, src, data);
        exp_lat = (op == OP_SWAP && SWAP_EN) ? 3 : 1;
        exp_err = (op == OP_ILL) || (op == OP_SWAP && !SWAP_EN);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_err"}, 64'(err_seen), 64'(exp_err));
        check({tag, "_regs"}, {rf_r[0], rf_r[1], rf_r[2], rf_r[3]},
                              {ref_r[0], ref_r[1], ref_r[2], ref_r[3]});
        check({tag, "_idle_ready"}, 64'(sn_idle_ready), 64'd1);
    endtask

    int acc [4];
    int nacc;
    logic [15:0] r2_before;
    logic [2:0] abort_op;
    int abort_steps;

    initial begin
        for (int k = 0; k < 4; k++) begin
            rf_r[k] = 16'h0; rf_s[k] = 16'h0; ref_r[k] = 16'h0;
        end
        // Reset with a command pending: must not be taken.
        Reset = 1'b1;
        CmdValid = 1'b1; CmdOp = OP_LDI; CmdDst = 2'd0; CmdSrc = 2'd0; CmdData = 16'hDEAD;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_ready", 64'(CmdReady), 64'd1);
        check("rst_done_err", {Done, Err}, 64'd0);
        check("rst_enables", {RfRegSel, RfScrSel}, 64'hFF);
        check("rst_fun_sel", {RfFunSel, RfOutASel, RfOutBSel}, 64'd0);
        check("rst_rfi", 64'(RfI), 64'd0);
        CmdValid = 1'b0;
        Reset = 1'b0;
        @(posedge Clock); #1;
        check("rst_no_accept", {rf_r[0], RfRegSel, 3'(CmdReady)}, {16'h0, 4'hF, 3'd1});

        run_cmd(OP_LDI, 2'd2, 2'd0, 16'hBEEF, "ldi");
        check("ldi_regsel", 64'(sn_regsel[1]), 64'b1101);
        check("ldi_funsel", 64'(sn_fun[1]), 64'b010);
        check("ldi_rfi", 64'(sn_rfi[1]), 64'hBEEF);
        check("ldi_done", 64'(sn_done[1]), 64'd1);
        check("ldi_done_after", 64'(sn_idle_done), 64'd0);

        run_cmd(OP_LDI, 2'd0, 2'd0, 16'h1234, "ldi_r1");
        run_cmd(OP_MOV, 2'd3, 2'd0, 16'h0000, "mov");
        check("mov_outasel", 64'(sn_outa[1]), 64'b000);
        check("mov_regsel", 64'(sn_regsel[1]), 64'b1110);
        check("mov_rfi", 64'(sn_rfi[1]), 64'h1234);
        check("mov_r4", 64'(rf_r[3]), 64'h1234);

        run_cmd(OP_MOV, 2'd2, 2'd2, 16'h0000, "mov_self");
        check("mov_self_r3", 64'(rf_r[2]), 64'hBEEF);

        run_cmd(OP_ILL, 2'd1, 2'd2, 16'h5A5A, "ill");
        check("ill_enables", {sn_regsel[1], sn_scrsel[1]}, 64'hFF);
        check("ill_done", 64'(sn_done[1]), 64'd1);
        check("ill_pulse_end", {sn_idle_done, sn_idle_err}, 64'd0);

`ifdef REGSEQ_SWAP_EN
        run_cmd(OP_LDI, 2'd0, 2'd0, 16'h0011, "ldi_s1");
        run_cmd(OP_LDI, 2'd1, 2'd0, 16'h0022, "ldi_s2");
        run_cmd(OP_SWAP, 2'd0, 2'd1, 16'h0000, "swap");
        check("swap_scrsel", 64'(sn_scrsel[1]), 64'b0111);
        check("swap_outa1", 64'(sn_outa[1]), 64'b000);
        check("swap_regsel2", 64'(sn_regsel[2]), 64'b0111);
        check("swap_regsel3", {sn_regsel[3], sn_outa[3]}, {4'b1011, 3'b100});
        check("swap_done_seq", {sn_done[1], sn_done[2], sn_done[3]}, 64'b001);
        check("swap_ready_seq", {sn_ready[1], sn_ready[2], sn_ready[3]}, 64'b000);
        check("swap_vals", {rf_r[0], rf_r[1]}, {16'h0022, 16'h0011});
        run_cmd(OP_SWAP, 2'd3, 2'd3, 16'h0000, "swap_self");
        check("swap_self_r4", 64'(rf_r[3]), 64'h1234);
`else
        run_cmd(OP_SWAP, 2'd0, 2'd1, 16'h0000, "op110");
        check("op110_enables", {sn_regsel[1], sn_scrsel[1]}, 64'hFF);
        check("op110_done", 64'(sn_done[1]), 64'd1);
        check("op110_scrsel_const", 64'(RfScrSel), 64'hF);
`endif

        // Back-to-back INC with CmdValid held high.
        r2_before = rf_r[1];
        CmdValid = 1'b1; CmdOp = OP_INC; CmdDst = 2'd1; CmdSrc = 2'd0; CmdData = 16'h0;
        nacc = 0;
        for (int i = 0; i < 20 && nacc < 4; i++) begin
            if (CmdReady) begin
                acc[nacc] = cyc;
                nacc++;
            end
            @(posedge Clock); #1;
        end
        CmdValid = 1'b0;
        @(posedge Clock); #1;
        check("b2b_count", 64'(nacc), 64'd4);
        for (int i = 0; i < 3; i++) check("b2b_gap", 64'(acc[i+1] - acc[i]), 64'd2);
        ref_r[1] = ref_r[1] + 16'd4;
        check("b2b_r2", 64'(rf_r[1]), 64'(r2_before + 16'd4));

        // Reset mid-command (SWAP2 when SWAP exists, EXEC of an LDI otherwise).
        abort_op = SWAP_EN ? OP_SWAP : OP_LDI;
        abort_steps = SWAP_EN ? 2 : 1;
        CmdValid = 1'b1; CmdOp = abort_op; CmdDst = 2'd2; CmdSrc = 2'd3; CmdData = 16'h7777;
        for (int i = 0; i < abort_steps; i++) begin
            @(posedge Clock); #1;
            CmdValid = 1'b0;
        end
        CmdValid = 1'b1; CmdOp = OP_LDI; CmdDst = 2'd1; CmdData = 16'hFFFF;
        Reset = 1'b1;
        #1;
        check("abort_enables", {RfRegSel, RfScrSel}, 64'hFF);
        check("abort_ready", 64'(CmdReady), 64'd1);
        check("abort_done_err", {Done, Err}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge Clock); #1;
            check("abort_no_done", 64'(Done), 64'd0);
        end
        CmdValid = 1'b0;
        Reset = 1'b0;
        @(posedge Clock); #1;
        check("abort_regs", {rf_r[0], rf_r[1], rf_r[2], rf_r[3]},
                            {ref_r[0], ref_r[1], ref_r[2], ref_r[3]});
        run_cmd(OP_LDI, 2'd2, 2'd0, 16'h4242, "post_rst_ldi");

        for (int n = 0; n < 150; n++) begin
            run_cmd(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 16'($urandom), "rnd");
        end

        check("onehot_viol", 64'(viol), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
